// File: rtl/sram_write_coalescer_if.sv
// sram_write_coalescer_if: bundles the allocation, DRAM response and SRAM write channels
// of sram_write_coalescer, plus its error pulse.
//   alloc_*  : request a row-gather slot (valid/ready), granted index on alloc_slot
//   rsp_*    : one DRAM beat for a slot, no back-pressure
//   wr_*     : completed row towards the scratchpad (valid/ready)
//   err      : one-cycle pulse for a rejected beat
// Modports: master = requester/backend side, slave = coalescer.
interface sram_write_coalescer_if #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned BEATS     = 4,
  parameter int unsigned BEAT_W    = 128,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned XBAR_W    = 8
) ();
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned BIDX_W = $clog2(BEATS);
  localparam int unsigned NB_W   = $clog2(BEATS + 1);

  logic                    alloc_valid;
  logic                    alloc_ready;
  logic [ADDR_W-1:0]       alloc_addr;
  logic [XBAR_W-1:0]       alloc_xbar;
  logic [NB_W-1:0]         alloc_nbeats;
  logic [SLOT_W-1:0]       alloc_slot;

  logic                    rsp_valid;
  logic [SLOT_W-1:0]       rsp_slot;
  logic [BIDX_W-1:0]       rsp_beat;
  logic [BEAT_W-1:0]       rsp_data;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [XBAR_W-1:0]       wr_xbar;
  logic [BEATS*BEAT_W-1:0] wr_data;
  logic [BEATS-1:0]        wr_mask;

  logic                    err;

  modport master (
    output alloc_valid, alloc_addr, alloc_xbar, alloc_nbeats,
    input  alloc_ready, alloc_slot,
    output rsp_valid, rsp_slot, rsp_beat, rsp_data,
    input  wr_valid, wr_addr, wr_xbar, wr_data, wr_mask,
    output wr_ready,
    input  err
  );

  modport slave (
    input  alloc_valid, alloc_addr, alloc_xbar, alloc_nbeats,
    output alloc_ready, alloc_slot,
    input  rsp_valid, rsp_slot, rsp_beat, rsp_data,
    output wr_valid, wr_addr, wr_xbar, wr_data, wr_mask,
    input  wr_ready,
    output err
  );
endinterface

// File: rtl/sram_write_coalescer.sv
// sram_write_coalescer: gathers out-of-order DRAM beats into full SRAM rows.
// Each of NUM_SLOTS slots is FREE, FILLING or FULL. A slot is allocated with a row address,
// crossbar control and expected beat count, collects beats in any order, and on its last
// beat is queued in a completion FIFO; rows are written out in completion order.
// Ports:
//   clk   : single clock
//   n_rst : synchronous active-low reset
//   bus   : sram_write_coalescer_if.slave (alloc_*, rsp_*, wr_*, err)
// Build option: define SCPAD_WCOAL_DUPCHK_EN to reject beats whose mask bit is already set
// (err pulse, no data/count update). Without it a repeated beat overwrites and counts.
module sram_write_coalescer #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned BEATS     = 4,
  parameter int unsigned BEAT_W    = 128,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned XBAR_W    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  sram_write_coalescer_if.slave bus
);
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned NB_W   = $clog2(BEATS + 1);
  localparam int unsigned ROW_W  = BEATS * BEAT_W;

  localparam logic [1:0] StFree    = 2'd0;
  localparam logic [1:0] StFilling = 2'd1;
  localparam logic [1:0] StFull    = 2'd2;

  logic [1:0]        state_q  [NUM_SLOTS];
  logic [1:0]        state_d  [NUM_SLOTS];
  logic [ADDR_W-1:0] addr_q   [NUM_SLOTS];
  logic [ADDR_W-1:0] addr_d   [NUM_SLOTS];
  logic [XBAR_W-1:0] xbar_q   [NUM_SLOTS];
  logic [XBAR_W-1:0] xbar_d   [NUM_SLOTS];
  logic [NB_W-1:0]   nbeats_q [NUM_SLOTS];
  logic [NB_W-1:0]   nbeats_d [NUM_SLOTS];
  logic [NB_W-1:0]   cnt_q    [NUM_SLOTS];
  logic [NB_W-1:0]   cnt_d    [NUM_SLOTS];
  logic [BEATS-1:0]  mask_q   [NUM_SLOTS];
  logic [BEATS-1:0]  mask_d   [NUM_SLOTS];
  logic [ROW_W-1:0]  data_q   [NUM_SLOTS];
  logic [ROW_W-1:0]  data_d   [NUM_SLOTS];

  logic [SLOT_W-1:0] fifo_q   [NUM_SLOTS];
  logic [SLOT_W-1:0] fifo_d   [NUM_SLOTS];
  logic [SLOT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [SLOT_W:0]   fill_q, fill_d;
  logic              err_q, err_d;

  logic              any_free;
  logic [SLOT_W-1:0] alloc_idx;
  logic [SLOT_W-1:0] head;
  logic [SLOT_W-1:0] rs;
  logic              alloc_fire;
  logic              drain;
  logic              push;
  logic              beat_ok;
  logic [NB_W-1:0]   alloc_nb_eff;
  logic [NB_W-1:0]   cnt_inc;
  int unsigned       beat_base;

  // Lowest-index free slot: scan downwards so the last hit is the lowest index.
  always_comb begin
    any_free  = 1'b0;
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] == StFree) begin
        any_free  = 1'b1;
        alloc_idx = SLOT_W'(i);
      end
    end
  end

  assign head       = fifo_q[rd_ptr_q];
  assign rs         = bus.rsp_slot;
  assign alloc_fire = bus.alloc_valid && any_free;
  assign drain      = bus.wr_valid && bus.wr_ready;
  assign beat_ok    = 32'(bus.rsp_beat) < BEATS;
  assign beat_base  = 32'(bus.rsp_beat) * BEAT_W;
  assign cnt_inc    = cnt_q[rs] + NB_W'(1);

  // Out-of-range or zero counts mean "a whole row".
  assign alloc_nb_eff = (bus.alloc_nbeats == '0 || bus.alloc_nbeats > NB_W'(BEATS)) ?
                        NB_W'(BEATS) : bus.alloc_nbeats;

  // Alloc only hits FREE slots, accepted beats only FILLING ones and drain only the FULL
  // head, so the three updates below can never collide on one slot.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    xbar_d   = xbar_q;
    nbeats_d = nbeats_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    data_d   = data_q;
    err_d    = 1'b0;
    push     = 1'b0;

    if (alloc_fire) begin
      state_d[alloc_idx]  = StFilling;
      addr_d[alloc_idx]   = bus.alloc_addr;
      xbar_d[alloc_idx]   = bus.alloc_xbar;
      nbeats_d[alloc_idx] = alloc_nb_eff;
      cnt_d[alloc_idx]    = '0;
      mask_d[alloc_idx]   = '0;
      // Clear stale lanes so short rows read zero in unreceived beats.
      data_d[alloc_idx]   = '0;
    end

    if (bus.rsp_valid) begin
      if (state_q[rs] != StFilling || !beat_ok) begin
        err_d = 1'b1;
`ifdef SCPAD_WCOAL_DUPCHK_EN
      end else if (mask_q[rs][bus.rsp_beat]) begin
        err_d = 1'b1;
`endif
      end else begin
        data_d[rs][beat_base +: BEAT_W] = bus.rsp_data;
        mask_d[rs][bus.rsp_beat]        = 1'b1;
        cnt_d[rs]                       = cnt_inc;
        if (cnt_inc == nbeats_q[rs]) begin
          state_d[rs] = StFull;
          push        = 1'b1;
        end
      end
    end

    if (drain) begin
      state_d[head] = StFree;
    end
  end

  // Completion FIFO; depth equals slot count so it cannot overflow.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = rs;
      wr_ptr_d         = wr_ptr_q + SLOT_W'(1);
    end
    if (drain) begin
      rd_ptr_d = rd_ptr_q + SLOT_W'(1);
    end
    fill_d = fill_q + (SLOT_W + 1)'(push) - (SLOT_W + 1)'(drain);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]  <= StFree;
        addr_q[i]   <= '0;
        xbar_q[i]   <= '0;
        nbeats_q[i] <= '0;
        cnt_q[i]    <= '0;
        mask_q[i]   <= '0;
        data_q[i]   <= '0;
        fifo_q[i]   <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      xbar_q   <= xbar_d;
      nbeats_q <= nbeats_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      err_q    <= err_d;
    end
  end

  assign bus.alloc_ready = any_free;
  assign bus.alloc_slot  = alloc_idx;
  assign bus.wr_valid    = (fill_q != '0);
  assign bus.wr_addr     = bus.wr_valid ? addr_q[head] : '0;
  assign bus.wr_xbar     = bus.wr_valid ? xbar_q[head] : '0;
  assign bus.wr_data     = bus.wr_valid ? data_q[head] : '0;
  assign bus.wr_mask     = bus.wr_valid ? mask_q[head] : '0;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_sram_write_coalescer.sv
// Testbench for sram_write_coalescer: directed stimulus, expected rows queued in a
// scoreboard and checked by an independent monitor on each write handshake.
module tb_sram_write_coalescer;
  localparam int unsigned ROW_W = 512;

  typedef struct {
    logic [11:0]      addr;
    logic [7:0]       xbar;
    logic [ROW_W-1:0] data;
    logic [3:0]       mask;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;

  sram_write_coalescer_if #(
    .NUM_SLOTS(4), .BEATS(4), .BEAT_W(128), .ADDR_W(12), .XBAR_W(8)
  ) bus ();

  sram_write_coalescer #(
    .NUM_SLOTS(4), .BEATS(4), .BEAT_W(128), .ADDR_W(12), .XBAR_W(8)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] mk(input logic [127:0] l0, input logic [127:0] l1,
                                          input logic [127:0] l2, input logic [127:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic push_exp(input logic [11:0] a, input logic [7:0] x, input logic [ROW_W-1:0] d,
                          input logic [3:0] m);
    exp_t e;
    e.addr = a; e.xbar = x; e.data = d; e.mask = m;
    sb.push_back(e);
  endtask

  // Monitor: every accepted write must match the oldest expected row.
  always @(negedge clk) begin
    if (n_rst && bus.wr_valid && bus.wr_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", ROW_W'(bus.wr_addr), ROW_W'(e.addr));
        chk("wr_xbar", ROW_W'(bus.wr_xbar), ROW_W'(e.xbar));
        chk("wr_data", bus.wr_data, e.data);
        chk("wr_mask", ROW_W'(bus.wr_mask), ROW_W'(e.mask));
      end
    end else if (n_rst && !bus.wr_valid) begin
      chk("idle_zero", ROW_W'({bus.wr_addr, bus.wr_xbar, bus.wr_mask}) | bus.wr_data, '0);
    end
  end

  task automatic do_alloc(input logic [11:0] a, input logic [7:0] x, input logic [2:0] nb,
                          input int exp_slot);
    chk("alloc_ready", ROW_W'(bus.alloc_ready), 1);
    chk("alloc_slot", ROW_W'(bus.alloc_slot), ROW_W'(exp_slot));
    bus.alloc_valid = 1'b1; bus.alloc_addr = a; bus.alloc_xbar = x; bus.alloc_nbeats = nb;
    @(posedge clk); #1;
    bus.alloc_valid = 1'b0;
  endtask

  task automatic send_beat(input int slot, input int beat, input logic [127:0] d);
    bus.rsp_valid = 1'b1; bus.rsp_slot = 2'(slot); bus.rsp_beat = 2'(beat); bus.rsp_data = d;
    @(posedge clk); #1;
    bus.rsp_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_done", ROW_W'(sb.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.alloc_valid = 1'b0; bus.alloc_addr = '0; bus.alloc_xbar = '0; bus.alloc_nbeats = '0;
    bus.rsp_valid = 1'b0; bus.rsp_slot = '0; bus.rsp_beat = '0; bus.rsp_data = '0;
    bus.wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    chk("rst_alloc_ready", ROW_W'(bus.alloc_ready), 1);
    chk("rst_alloc_slot", ROW_W'(bus.alloc_slot), 0);
    chk("rst_wr_valid", ROW_W'(bus.wr_valid), 0);
    chk("rst_err", ROW_W'(bus.err), 0);

    // Out-of-order full row; write appears right after the final beat.
    push_exp(12'h010, 8'h05, mk(128'hC, 128'hB, 128'hD, 128'hA), 4'hF);
    do_alloc(12'h010, 8'h05, 3'd4, 0);
    send_beat(0, 3, 128'hA);
    send_beat(0, 1, 128'hB);
    send_beat(0, 0, 128'hC);
    chk("pre_final_wr_valid", ROW_W'(bus.wr_valid), 0);
    send_beat(0, 2, 128'hD);
    chk("latency_wr_valid", ROW_W'(bus.wr_valid), 1);
    wait_empty();

    // Short row reusing slot 0: upper lanes must read zero.
    push_exp(12'h020, 8'h06, mk(128'h11, 128'h22, 128'h0, 128'h0), 4'b0011);
    do_alloc(12'h020, 8'h06, 3'd2, 0);
    send_beat(0, 0, 128'h11);
    send_beat(0, 1, 128'h22);
    wait_empty();

    // nbeats=0 means a whole row.
    push_exp(12'h030, 8'h07, mk(128'h1, 128'h2, 128'h3, 128'h4), 4'hF);
    do_alloc(12'h030, 8'h07, 3'd0, 0);
    send_beat(0, 0, 128'h1);
    send_beat(0, 1, 128'h2);
    send_beat(0, 2, 128'h3);
    chk("nb0_not_full", ROW_W'(bus.wr_valid), 0);
    send_beat(0, 3, 128'h4);
    wait_empty();

    // Completion order with a stalled backend.
    bus.wr_ready = 1'b0;
    do_alloc(12'h100, 8'h10, 3'd2, 0);
    do_alloc(12'h200, 8'h20, 3'd2, 1);
    push_exp(12'h200, 8'h20, mk(128'h21, 128'h22, 128'h0, 128'h0), 4'b0011);
    push_exp(12'h100, 8'h10, mk(128'h11, 128'h12, 128'h0, 128'h0), 4'b0011);
    send_beat(1, 1, 128'h22);
    send_beat(1, 0, 128'h21);
    send_beat(0, 0, 128'h11);
    send_beat(0, 1, 128'h12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", ROW_W'(bus.wr_valid), 1);
      chk("stall_addr", ROW_W'(bus.wr_addr), ROW_W'(12'h200));
      chk("stall_data", bus.wr_data, mk(128'h21, 128'h22, 128'h0, 128'h0));
    end
    @(posedge clk); #1;
    bus.wr_ready = 1'b1;
    wait_empty();

    // Exhaust slots, then free one.
    bus.wr_ready = 1'b0;
    do_alloc(12'h300, 8'h30, 3'd1, 0);
    do_alloc(12'h301, 8'h31, 3'd1, 1);
    do_alloc(12'h302, 8'h32, 3'd1, 2);
    do_alloc(12'h303, 8'h33, 3'd1, 3);
    chk("full_alloc_ready", ROW_W'(bus.alloc_ready), 0);
    push_exp(12'h302, 8'h32, mk(128'h52, 128'h0, 128'h0, 128'h0), 4'b0001);
    send_beat(2, 0, 128'h52);
    bus.wr_ready = 1'b1;
    @(posedge clk); #1;
    bus.wr_ready = 1'b0;
    chk("freed_alloc_ready", ROW_W'(bus.alloc_ready), 1);
    chk("freed_alloc_slot", ROW_W'(bus.alloc_slot), 2);
    push_exp(12'h300, 8'h30, mk(128'h50, 128'h0, 128'h0, 128'h0), 4'b0001);
    push_exp(12'h301, 8'h31, mk(128'h51, 128'h0, 128'h0, 128'h0), 4'b0001);
    push_exp(12'h303, 8'h33, mk(128'h53, 128'h0, 128'h0, 128'h0), 4'b0001);
    send_beat(0, 0, 128'h50);
    send_beat(1, 0, 128'h51);
    send_beat(3, 0, 128'h53);
    bus.wr_ready = 1'b1;
    wait_empty();

    // Beat to a free slot.
    send_beat(1, 0, 128'hBAD);
    chk("free_err_pulse", ROW_W'(bus.err), 1);
    @(posedge clk); #1;
    chk("free_err_clear", ROW_W'(bus.err), 0);
    chk("free_no_change_ready", ROW_W'(bus.alloc_ready), 1);
    chk("free_no_change_slot", ROW_W'(bus.alloc_slot), 0);
    chk("free_no_change_valid", ROW_W'(bus.wr_valid), 0);

    // Duplicate beat.
    do_alloc(12'h040, 8'h44, 3'd2, 0);
    send_beat(0, 1, 128'h55);
`ifdef SCPAD_WCOAL_DUPCHK_EN
    push_exp(12'h040, 8'h44, mk(128'h77, 128'h55, 128'h0, 128'h0), 4'b0011);
    send_beat(0, 1, 128'h66);
    chk("dup_err_pulse", ROW_W'(bus.err), 1);
    chk("dup_not_full", ROW_W'(bus.wr_valid), 0);
    send_beat(0, 0, 128'h77);
`else
    push_exp(12'h040, 8'h44, mk(128'h0, 128'h66, 128'h0, 128'h0), 4'b0010);
    send_beat(0, 1, 128'h66);
    chk("dup_no_err", ROW_W'(bus.err), 0);
`endif
    wait_empty();

    // Reset with a half-filled row.
    do_alloc(12'h0AA, 8'h0A, 3'd4, 0);
    send_beat(0, 0, 128'h1);
    send_beat(0, 1, 128'h2);
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    chk("mid_rst_ready", ROW_W'(bus.alloc_ready), 1);
    chk("mid_rst_slot", ROW_W'(bus.alloc_slot), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_wr_valid", ROW_W'(bus.wr_valid), 0);
    end
    push_exp(12'h0BB, 8'h0B, mk(128'h99, 128'h0, 128'h0, 128'h0), 4'b0001);
    do_alloc(12'h0BB, 8'h0B, 3'd1, 0);
    send_beat(0, 0, 128'h99);
    wait_empty();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
